// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg
// Shared constants for the 5-stage core pipeline controller.
//   - FSM state encodings (RUN, MD_WAIT)
//   - PC source select encodings (predictor vs. EX recovery target)
//   - default width of the statistics counters
package core_pipe_pkg;

    localparam logic RUN          = 1'b0;
    localparam logic MD_WAIT      = 1'b1;

    localparam logic PC_SEL_PRED  = 1'b0;
    localparam logic PC_SEL_RECOV = 1'b1;

    localparam int   CNT_W_DEF    = 16;

endpackage

// File: rtl/core_sat_cnt.sv
// core_sat_cnt
// W-bit up-counter that increments when en=1 and sticks at all-ones.
// Ports:
//   clk  in   core clock
//   rst  in   asynchronous active-low reset (clears the count)
//   en   in   increment request for this cycle
//   cnt  out  current count
module core_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl
// Sequencing controller for the 5-stage core. Produces the write enables
// and flush strobes for the PC and the four inter-stage registers, plus
// the PC source select, resolving hazards in a fixed priority:
// dcache stall > mispredict > mul/div occupancy > load-use > icache miss.
// Ports:
//   clk, rst (async, active-low)
//   icache_miss, dcache_miss         cache status for this cycle
//   id_rs, id_rt                     sources of the instruction in IF/ID
//   ex_mem_read, ex_rt               load in EX and its destination
//   ex_mispred                       branch in EX mispredicted
//   md_start                         mul/div entered EX this cycle
//   pc_we, pc_sel                    PC update enable / source select
//   *_we, *_flush                    inter-stage register controls
//   md_busy                          FSM is in MD_WAIT
//   stall_cycles, flush_events       saturating statistics
//
// Handshake: there is no valid/ready pair here; every strobe is a
// same-cycle combinational function of inputs and registered state, and
// the pipeline registers consume it on the next rising edge. A flush
// overrides the write enable of the same register.
module core_pipe_ctrl
    import core_pipe_pkg::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mispred,
    input  logic             md_start,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic       state, state_nxt;
    logic [7:0] md_cnt, md_cnt_nxt;
    logic       load_use;
    logic       mispred_evt;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            md_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        md_cnt_nxt   = md_cnt;
        pc_we        = 1'b1;
        pc_sel       = PC_SEL_PRED;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_flush     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mispred_evt  = 1'b0;

        if (dcache_miss) begin
            // Full freeze: FSM and md_cnt hold, a pending mispredict
            // waits in EX until the freeze lifts.
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if ((state == RUN) && ex_mispred) begin
            // A mul/div start in the same cycle is on the wrong path.
            pc_sel      = PC_SEL_RECOV;
            if_flush    = 1'b1;
            id_ex_flush = 1'b1;
            mispred_evt = 1'b1;
        end else if (((state == MD_WAIT) && (md_cnt != 8'd0)) ||
                     ((state == RUN) && md_start)) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_flush = 1'b1;
            if (state == RUN) begin
                // The start cycle and the release cycle account for two
                // of the MD_CYCLES occupancy cycles.
                md_cnt_nxt = 8'(MD_CYCLES - 2);
                state_nxt  = MD_WAIT;
            end else begin
                md_cnt_nxt = md_cnt - 8'd1;
            end
        end else begin
            // Release cycle of a mul/div behaves like a RUN cycle.
            state_nxt = RUN;
            if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (icache_miss) begin
                pc_we    = 1'b0;
                if_flush = 1'b1;
            end
        end

        // While reset is held every strobe is inactive.
        if (!rst) begin
            pc_we        = 1'b0;
            pc_sel       = PC_SEL_PRED;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
            if_flush     = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            mispred_evt  = 1'b0;
        end
    end

    assign md_busy = (state == MD_WAIT);

    core_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (!pc_we),
        .cnt (stall_cycles)
    );

    core_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (mispred_evt),
        .cnt (flush_events)
    );

endmodule

// File: tb/tb_core_pipe_ctrl.sv
module tb_core_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss, dcache_miss;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, ex_mispred, md_start;
    logic        pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_flush, id_ex_flush, ex_mem_flush, md_busy;
    logic [15:0] stall_cycles, flush_events;

    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    core_pipe_ctrl #(.MD_CYCLES(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_miss  (icache_miss),
        .dcache_miss  (dcache_miss),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .ex_mispred   (ex_mispred),
        .md_start     (md_start),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .if_flush     (if_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    // driver tasks
    task automatic idle();
        icache_miss = 1'b0;
        dcache_miss = 1'b0;
        id_rs       = 5'd1;
        id_rt       = 5'd2;
        ex_mem_read = 1'b0;
        ex_rt       = 5'd0;
        ex_mispred  = 1'b0;
        md_start    = 1'b0;
    endtask

    // advance one cycle; inputs set after return are sampled 1 time unit
    // past the edge, away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe vector {pc_we,pc_sel,if_id_we,id_ex_we,ex_mem_we,mem_wb_we,
    //                if_flush,id_ex_flush,ex_mem_flush}
    function automatic logic [8:0] strobes();
        return {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                if_flush, id_ex_flush, ex_mem_flush};
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        #1;
        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            chk("reset_strobes", 32'(strobes()), 32'h000);
            chk("reset_md_busy", 32'(md_busy), 32'h0);
            chk("reset_stall", 32'(stall_cycles), 32'h0);
            chk("reset_flush", 32'(flush_events), 32'h0);
            tick();
        end
        rst = 1'b1;
        #1;

        // no hazards for 10 cycles
        for (int i = 0; i < 10; i++) begin
            chk("run_strobes", 32'(strobes()), 32'b1_0_1111_000);
            tick();
        end
        chk("run_stall_zero", 32'(stall_cycles), 32'h0);

        // load-use on rs
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk("lu_rs_strobes", 32'(strobes()), 32'b0_0_0111_010);
        tick();
        // ex_rt = 0 never stalls
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_r0_strobes", 32'(strobes()), 32'b1_0_1111_000);
        tick();
        chk("lu_stall1", 32'(stall_cycles), 32'd1);
        // load-use on rt
        idle(); ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7;
        #1;
        chk("lu_rt_strobes", 32'(strobes()), 32'b0_0_0111_010);
        tick();
        // icache miss alone
        idle(); icache_miss = 1'b1;
        #1;
        chk("ic_strobes", 32'(strobes()), 32'b0_0_1111_100);
        tick();
        // load-use outranks icache miss
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        #1;
        chk("lu_over_ic", 32'(strobes()), 32'b0_0_0111_010);
        tick();
        idle();
        #1;
        chk("stall_after_lu_ic", 32'(stall_cycles), 32'd4);

        // mul/div, MD_CYCLES=4
        md_start = 1'b1;
        #1;
        chk("md_c1_strobes", 32'(strobes()), 32'b0_0_0011_001);
        chk("md_c1_busy", 32'(md_busy), 32'h0);
        tick();
        md_start = 1'b0;
        #1;
        chk("md_c2_strobes", 32'(strobes()), 32'b0_0_0011_001);
        chk("md_c2_busy", 32'(md_busy), 32'h1);
        tick();
        chk("md_c3_strobes", 32'(strobes()), 32'b0_0_0011_001);
        chk("md_c3_busy", 32'(md_busy), 32'h1);
        tick();
        chk("md_c4_release", 32'(strobes()), 32'b1_0_1111_000);
        chk("md_c4_busy", 32'(md_busy), 32'h1);
        tick();
        chk("md_c5_busy", 32'(md_busy), 32'h0);
        chk("md_stall", 32'(stall_cycles), 32'd7);

        // mul/div with a 2-cycle dcache freeze in MD_WAIT
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        #1;
        chk("mdd_c2_pc_we", 32'(pc_we), 32'h0);
        tick();
        dcache_miss = 1'b1;
        #1;
        chk("mdd_freeze1", 32'(strobes()), 32'h000);
        chk("mdd_freeze_busy", 32'(md_busy), 32'h1);
        tick();
        chk("mdd_freeze2", 32'(strobes()), 32'h000);
        tick();
        // still one countdown cycle left; mispredict ignored in MD_WAIT
        dcache_miss = 1'b0; ex_mispred = 1'b1;
        #1;
        chk("mdd_c5_stall", 32'(strobes()), 32'b0_0_0011_001);
        tick();
        ex_mispred = 1'b0;
        #1;
        chk("mdd_release", 32'(strobes()), 32'b1_0_1111_000);
        chk("mdd_flush_ignored", 32'(flush_events), 32'h0);
        tick();
        chk("mdd_stall", 32'(stall_cycles), 32'd12);

        // mispredict with icache miss and a same-cycle md_start
        ex_mispred = 1'b1; icache_miss = 1'b1; md_start = 1'b1;
        #1;
        chk("mp_strobes", 32'(strobes()), 32'b1_1_1111_110);
        chk("mp_flush_before", 32'(flush_events), 32'h0);
        tick();
        idle();
        #1;
        chk("mp_flush_after", 32'(flush_events), 32'h1);
        chk("mp_md_ignored", 32'(md_busy), 32'h0);
        chk("mp_stall", 32'(stall_cycles), 32'd12);

        // dcache + mispredict: freeze, then mispredict on release
        dcache_miss = 1'b1; ex_mispred = 1'b1;
        #1;
        chk("dm_freeze", 32'(strobes()), 32'h000);
        tick();
        chk("dm_flush_held", 32'(flush_events), 32'h1);
        dcache_miss = 1'b0;
        #1;
        chk("dm_release", 32'(strobes()), 32'b1_1_1111_110);
        tick();
        idle();
        #1;
        chk("dm_flush_after", 32'(flush_events), 32'h2);
        chk("dm_stall", 32'(stall_cycles), 32'd13);

        // reset in the middle of MD_WAIT
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        #1;
        chk("rmd_busy", 32'(md_busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("rmd_strobes", 32'(strobes()), 32'h000);
        chk("rmd_busy_cleared", 32'(md_busy), 32'h0);
        chk("rmd_stall_cleared", 32'(stall_cycles), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("rmd_run", 32'(strobes()), 32'b1_0_1111_000);
        chk("rmd_run_busy", 32'(md_busy), 32'h0);

        // flush_events saturation
        ex_mispred = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", 32'(flush_events), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(flush_events), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(flush_events), 32'hFFFF);
        chk("sat_stall_zero", 32'(stall_cycles), 32'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
